// File: rtl/spi_slave_responder_if.sv
// Bus bundle for the SPI slave responder: SPI pin set plus the TX/RX
// valid/ready holding-register handshakes and status pulses.
interface spi_slave_responder_if #(
  parameter int DATA_W = 8
);
  logic              SCLK;
  logic              SSn;
  logic              MOSI;
  logic              MISO;
  logic              MISO_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              overrun;
  logic              underrun;
  logic              busy;

  modport slave (
    input  SCLK, SSn, MOSI, tx_data, tx_valid, rx_ready,
    output MISO, MISO_oe, tx_ready, rx_data, rx_valid, overrun, underrun, busy
  );

  modport master (
    output SCLK, SSn, MOSI, tx_data, tx_valid, rx_ready,
    input  MISO, MISO_oe, tx_ready, rx_data, rx_valid, overrun, underrun, busy
  );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave, MSB first, with the SPI pins oversampled in the HCLK
// domain and single-entry TX/RX holding registers on the system side.
module spi_slave_responder #(
  parameter int   DATA_W      = 8,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  spi_slave_responder_if.slave   bus
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   ss_d;
  logic                   sclk_s;
  logic                   ss_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   ss_rise;
  logic                   ss_fall;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      tx_shift;
  logic [DATA_W-2:0]      rx_shift;
  logic [DATA_W-1:0]      tx_hold;
  logic                   tx_ready_r;
  logic [DATA_W-1:0]      rx_data_r;
  logic                   rx_valid_r;
  logic                   overrun_r;
  logic                   underrun_r;
  logic                   busy_r;
  logic                   miso_oe_r;

  logic [DATA_W-1:0]      rx_word;
  logic [DATA_W-1:0]      load_val;
  logic                   load_empty;

  // Input synchronizers plus one extra flop on SCLK/SSn for edge detection.
  // The SSn chain resets to the selected level so that an SSn already low
  // when reset releases never produces a falling edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.SSn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;
  assign ss_rise   =  ss_s   & ~ss_d;
  assign ss_fall   = ~ss_s   &  ss_d;

  // Next RX word (the stored DATA_W-1 bits plus the bit being sampled) and
  // the TX shifter load source: holder when full, idle fill when empty.
  always_comb begin
    rx_word    = {rx_shift, mosi_s};
    load_empty = tx_ready_r;
    load_val   = tx_ready_r ? {DATA_W{IDLE_MISO}} : tx_hold;
  end

  // Frame FSM with holding-register handshakes and status pulses.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      tx_hold    <= '0;
      tx_ready_r <= 1'b1;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
      busy_r     <= 1'b0;
      miso_oe_r  <= 1'b0;
    end else begin
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;

      // Accept and load are exclusive: accept needs an empty holder, a load
      // from the holder needs a full one.
      if (bus.tx_valid && tx_ready_r) begin
        tx_hold    <= bus.tx_data;
        tx_ready_r <= 1'b0;
      end

      if (rx_valid_r && bus.rx_ready) begin
        rx_valid_r <= 1'b0;
      end

      case (state)
        IDLE: begin
          busy_r    <= 1'b0;
          miso_oe_r <= 1'b0;
          if (ss_fall) begin
            state     <= ACTIVE;
            busy_r    <= 1'b1;
            miso_oe_r <= 1'b1;
            bit_cnt   <= '0;
            tx_shift  <= load_val;
            if (load_empty) begin
              underrun_r <= 1'b1;
            end else begin
              tx_ready_r <= 1'b1;
            end
          end
        end

        ACTIVE: begin
          if (ss_rise) begin
            // Deselect wins over a coincident SCLK edge; partial words and
            // any word already in the TX shifter are dropped.
            state     <= IDLE;
            busy_r    <= 1'b0;
            miso_oe_r <= 1'b0;
            bit_cnt   <= '0;
          end else if (sclk_rise) begin
            if (bit_cnt == LAST_BIT) begin
              rx_data_r  <= rx_word;
              rx_valid_r <= 1'b1;
              overrun_r  <= rx_valid_r && !bus.rx_ready;
              bit_cnt    <= '0;
            end else begin
              rx_shift <= rx_word[DATA_W-2:0];
              bit_cnt  <= bit_cnt + CNT_W'(1);
            end
          end else if (sclk_fall) begin
            if (bit_cnt != '0) begin
              tx_shift <= {tx_shift[DATA_W-2:0], IDLE_MISO};
            end else begin
              // Word boundary with SSn still low: start the next word.
              tx_shift <= load_val;
              if (load_empty) begin
                underrun_r <= 1'b1;
              end else begin
                tx_ready_r <= 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MISO     = miso_oe_r ? tx_shift[DATA_W-1] : IDLE_MISO;
  assign bus.MISO_oe  = miso_oe_r;
  assign bus.tx_ready = tx_ready_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.overrun  = overrun_r;
  assign bus.underrun = underrun_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed-plus-random bench for spi_slave_responder acting as an SPI master
// with a frame-level reference model of the TX holder and expected words.
module tb_spi_slave_responder;

  localparam int DW = 8;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;

  always #5 HCLK = ~HCLK;

  spi_slave_responder_if #(.DATA_W(DW)) bus ();

  spi_slave_responder #(
    .DATA_W      (DW),
    .SYNC_STAGES (2),
    .IDLE_MISO   (1'b0)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Pulse counters and accepted RX words seen on the bus.
  int         ovr_cnt = 0;
  int         und_cnt = 0;
  logic [7:0] rx_got[$];

  // Reference model: TX holder occupancy and the queue of words the
  // master should see, one entry per word loaded into the slave shifter.
  bit         hold_full = 1'b0;
  logic [7:0] hold_val  = 8'h00;
  logic [7:0] exp_miso_q[$];
  int         exp_under = 0;

  always begin
    @(negedge HCLK);
    #1;
    if (bus.overrun === 1'b1) ovr_cnt++;
    if (bus.underrun === 1'b1) und_cnt++;
    if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) rx_got.push_back(bus.rx_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic model_load();
    if (hold_full) begin
      exp_miso_q.push_back(hold_val);
      hold_full = 1'b0;
    end else begin
      exp_miso_q.push_back(8'h00);
      exp_under++;
    end
  endtask

  task automatic tx_write(input logic [7:0] v);
    logic ok;
    ok = 1'b0;
    bus.tx_data  = v;
    bus.tx_valid = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      ok = bus.tx_ready;
      @(negedge HCLK);
    end
    bus.tx_valid = 1'b0;
    check("tx_accept", {31'd0, ok}, 32'd1);
    if (ok) begin
      hold_full = 1'b1;
      hold_val  = v;
    end
  endtask

  task automatic ss_low();
    bus.SSn = 1'b0;
    repeat (8) @(negedge HCLK);
    model_load();
  endtask

  task automatic ss_high();
    bus.SSn = 1'b1;
    repeat (8) @(negedge HCLK);
    exp_miso_q.delete();
  endtask

  // Master side of nbits SPI mode-0 bits, SCLK = HCLK/16. MISO is sampled
  // just before each rising edge; lat is rx_valid 5 HCLK after the last rise.
  task automatic spi_bits(input logic [7:0] w, input int nbits,
                          output logic [7:0] got, output logic lat);
    got = 8'h00;
    lat = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = w[7-i];
      repeat (8) @(negedge HCLK);
      got = {got[6:0], bus.MISO};
      bus.SCLK = 1'b1;
      repeat (5) @(negedge HCLK);
      lat = bus.rx_valid;
      repeat (3) @(negedge HCLK);
      bus.SCLK = 1'b0;
    end
    repeat (8) @(negedge HCLK);
  endtask

  // One full word; the trailing SCLK fall with SSn low reloads the shifter.
  task automatic xfer(input logic [7:0] m, input string tag, output logic lat);
    logic [7:0] got;
    logic [7:0] exp;
    exp = (exp_miso_q.size() != 0) ? exp_miso_q.pop_front() : 8'hxx;
    spi_bits(m, 8, got, lat);
    check({tag, "_miso"}, {24'd0, got}, {24'd0, exp});
    model_load();
  endtask

  initial begin
    logic       lat;
    logic [7:0] t;
    logic [7:0] m;
    logic [7:0] w[3];
    logic [7:0] pg;
    int         rb;
    int         ob;
    int         ub;

    bus.SCLK     = 1'b0;
    bus.SSn      = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b1;
    repeat (4) @(negedge HCLK);

    check("rst_miso",     {31'd0, bus.MISO},     32'd0);
    check("rst_miso_oe",  {31'd0, bus.MISO_oe},  32'd0);
    check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_rx_data",  {24'd0, bus.rx_data},  32'd0);
    check("rst_overrun",  {31'd0, bus.overrun},  32'd0);
    check("rst_underrun", {31'd0, bus.underrun}, 32'd0);
    check("rst_busy",     {31'd0, bus.busy},     32'd0);

    HRESETn = 1'b1;
    repeat (6) @(negedge HCLK);

    // Single frame: slave returns 0xA5 while receiving 0x3C.
    bus.rx_ready = 1'b0;
    tx_write(8'hA5);
    ss_low();
    check("t1_underrun_at_fall", und_cnt, exp_under);
    check("t1_busy",    {31'd0, bus.busy},    32'd1);
    check("t1_miso_oe", {31'd0, bus.MISO_oe}, 32'd1);
    xfer(8'h3C, "t1", lat);
    check("t1_rx_valid_latency", {31'd0, lat}, 32'd1);
    check("t1_rx_data",  {24'd0, bus.rx_data},  32'h3C);
    check("t1_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
    ss_high();
    bus.rx_ready = 1'b1;
    repeat (3) @(negedge HCLK);
    check("t1_rx_drained", {31'd0, bus.rx_valid}, 32'd0);
    check("t1_underrun_total", und_cnt, exp_under);

    // Random single frames.
    for (int k = 0; k < 3; k++) begin
      t  = 8'($urandom);
      m  = 8'($urandom);
      rb = rx_got.size();
      tx_write(t);
      ss_low();
      xfer(m, "rnd", lat);
      ss_high();
      check("rnd_rx_count", rx_got.size(), rb + 1);
      check("rnd_rx_data", {24'd0, rx_got[rb]}, {24'd0, m});
      check("rnd_underrun", und_cnt, exp_under);
    end

    // Back-to-back words without SSn toggling.
    for (int k = 0; k < 3; k++) w[k] = 8'($urandom);
    rb = rx_got.size();
    tx_write(w[0]);
    ss_low();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) tx_write(w[k+1]);
      xfer(8'(k + 1), "b2b", lat);
    end
    ss_high();
    check("b2b_rx_count", rx_got.size(), rb + 3);
    for (int k = 0; k < 3; k++) begin
      check("b2b_rx_data", {24'd0, rx_got[rb+k]}, k + 1);
    end
    check("b2b_underrun", und_cnt, exp_under);

    // Overrun: consumer stalled across two completions.
    bus.rx_ready = 1'b0;
    ob = ovr_cnt;
    ss_low();
    xfer(8'h11, "ovr", lat);
    check("ovr_none_first", ovr_cnt, ob);
    xfer(8'h22, "ovr", lat);
    ss_high();
    check("ovr_pulse", ovr_cnt, ob + 1);
    check("ovr_rx_data",  {24'd0, bus.rx_data},  32'h22);
    check("ovr_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
    bus.rx_ready = 1'b1;
    repeat (3) @(negedge HCLK);
    check("ovr_drained", {31'd0, bus.rx_valid}, 32'd0);
    check("ovr_underrun", und_cnt, exp_under);

    // Underrun: no TX data at the SSn fall.
    ub = und_cnt;
    rb = rx_got.size();
    ss_low();
    check("und_pulse_at_fall", und_cnt, ub + 1);
    xfer(8'hFF, "und", lat);
    ss_high();
    check("und_rx_data", {24'd0, rx_got[rb]}, 32'hFF);
    check("und_underrun", und_cnt, exp_under);

    // Abort after 5 bits, then a clean frame.
    rb = rx_got.size();
    tx_write(8'($urandom));
    ss_low();
    spi_bits(8'hC3, 5, pg, lat);
    bus.SSn = 1'b1;
    repeat (4) @(negedge HCLK);
    check("abort_busy",    {31'd0, bus.busy},    32'd0);
    check("abort_miso_oe", {31'd0, bus.MISO_oe}, 32'd0);
    repeat (4) @(negedge HCLK);
    exp_miso_q.delete();
    check("abort_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("abort_rx_count", rx_got.size(), rb);
    t = 8'($urandom);
    tx_write(t);
    ss_low();
    xfer(8'h5A, "post_abort", lat);
    ss_high();
    check("post_abort_rx", {24'd0, rx_got[rb]}, 32'h5A);
    check("abort_underrun", und_cnt, exp_under);

    // Reset mid-frame with SSn held low.
    tx_write(8'($urandom));
    ss_low();
    spi_bits(8'($urandom), 3, pg, lat);
    HRESETn = 1'b0;
    #1;
    hold_full = 1'b0;
    exp_miso_q.delete();
    check("mrst_busy",     {31'd0, bus.busy},     32'd0);
    check("mrst_miso_oe",  {31'd0, bus.MISO_oe},  32'd0);
    check("mrst_miso",     {31'd0, bus.MISO},     32'd0);
    check("mrst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("mrst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("mrst_rx_data",  {24'd0, bus.rx_data},  32'd0);
    ub = und_cnt;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (20) @(negedge HCLK);
    check("mrst_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("mrst_idle_oe",   {31'd0, bus.MISO_oe}, 32'd0);
    check("mrst_no_underrun", und_cnt, ub);
    ss_high();
    rb = rx_got.size();
    t  = 8'($urandom);
    m  = 8'($urandom);
    tx_write(t);
    ss_low();
    xfer(m, "post_rst", lat);
    ss_high();
    check("post_rst_rx", {24'd0, rx_got[rb]}, {24'd0, m});
    check("post_rst_underrun", und_cnt, exp_under);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
SPI mode-0 slave, 8-bit frames, MSB first. It is the responder end for the SoC's SPI master peripheral (MSI/MSO/SSn/SCLK pin set). Used as a loopback/verification responder and as an on-chip slave peripheral. The SPI pins are oversampled in the HCLK domain. On the system side, one single-entry TX holding register and one single-entry RX holding register connect through valid/ready handshakes.

Parameters:
DATA_W, 8, frame width in bits (supported range 4..32)
SYNC_STAGES, 2, synchronizer depth for SCLK, SSn and MOSI (2..3)
IDLE_MISO, 1'b0, MISO level driven while SSn is high or when no TX data is available

Ports:
HCLK  in  1  system clock; all logic on its rising edge
HRESETn  in  1  asynchronous, active-low reset
SCLK  in  1  SPI clock from master, idle low
SSn  in  1  slave select from master, active low
MOSI  in  1  serial data from master (master's MSO)
MISO  out  1  serial data to master (master's MSI)
MISO_oe  out  1  high while the selected frame is active
tx_data  in  DATA_W  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX holding register empty
rx_data  out  DATA_W  last received word
rx_valid  out  1  rx_data valid
rx_ready  in  1  consumer accepts rx_data
overrun  out  1  1-cycle pulse: a received word is lost
underrun  out  1  1-cycle pulse: a frame started with the TX holder empty
busy  out  1  high in ACTIVE state

Behaviour:
- Reset values:
  - MISO = IDLE_MISO; MISO_oe = 0; tx_ready = 1; rx_valid = 0; rx_data = 0; overrun = 0; underrun = 0; busy = 0.
  - Shifters, bit counter and TX holder are cleared; state = IDLE.
- Input conditioning:
  - SCLK, SSn and MOSI each pass through SYNC_STAGES flops.
  - Edge detect uses a further flop on synced SCLK and synced SSn.
  - Requirement: HCLK >= 10x SCLK, with each SCLK phase >= 5 HCLK.
- TX handshake:
  - Transfer occurs when tx_valid && tx_ready.
  - tx_ready falls the next cycle and rises again the cycle after the holder is loaded into the TX shifter.
- RX handshake:
  - Transfer occurs when rx_valid && rx_ready; rx_valid clears the next cycle.
  - rx_data is stable while rx_valid = 1, except on overrun.
- State IDLE:
  - MISO = IDLE_MISO, MISO_oe = 0.
  - On synced SSn falling edge: go to ACTIVE, bit count = 0, and load the TX shifter.
  - Load source is the TX holder if full; otherwise all IDLE_MISO bits with a 1-cycle underrun pulse.
  - MISO = shifter MSB in the cycle after the load.
- State ACTIVE: busy = 1, MISO_oe = 1.
  - Synced SCLK rising edge: sample synced MOSI into the RX shifter LSB (shift left), then count++.
  - Synced SCLK falling edge with count != 0: shift TX left, so MISO presents the next bit.
  - Word completion (count reaches DATA_W on a rising edge):
    - The RX shifter value, including the just-sampled bit, goes to rx_data; rx_valid = 1 on the next cycle.
    - If rx_valid was already 1 and is not being accepted that same cycle, rx_data is overwritten and overrun pulses for 1 cycle.
    - count returns to 0.
  - Falling edge with count == 0 (after a completed word, SSn still low): reload the TX shifter from the holder, or underrun as in IDLE. Back-to-back words need no SSn toggle.
  - Synced SSn rising edge: return to IDLE in the next cycle.
    - A partial word (0 < count < DATA_W) is discarded, with no rx_valid and no overrun.
    - A TX word already loaded into the shifter is consumed, not returned to the holder.
- Simultaneous events:
  - SSn rising and SCLK rising in the same synced cycle: SSn wins and no bit is sampled.
  - RX completion while rx_ready accepts the old word: old word accepted, new word loaded, no overrun.
  - tx_valid accepted in the same cycle as a reload: the reload uses the previous holder state (empty gives underrun); the new word waits for the next frame boundary.
- Reset asserted mid-frame: all state clears immediately (async). After deassert the block stays in IDLE until a fresh synced SSn falling edge; an already-low SSn is ignored.
- No combinational path from any input to any output.

Test Plan:
- Single frame: preload tx_data = 0xA5; master sends 0x3C (SCLK = HCLK/16) -> master receives 0xA5; rx_data = 0x3C with rx_valid = 1 ~3-4 HCLK after the 8th rising edge; underrun = 0.
- Back-to-back: SSn held low for 3 words; TX holder refilled after each tx_ready; master sends 0x01, 0x02, 0x03 -> MISO words match the TX writes in order; rx_data sequence is 0x01, 0x02, 0x03 with rx_ready always 1.
- Overrun: rx_ready = 0, master sends 0x11 then 0x22 -> one overrun pulse on the 2nd completion; rx_data = 0x22; rx_valid stays 1.
- Underrun: no TX write, master sends 0xFF -> underrun pulse at the SSn fall; master receives 0x00; rx_data = 0xFF.
- Abort: SSn rises after 5 bits of 0xC3 -> no rx_valid, busy = 0 within SYNC_STAGES+2 cycles; the next full frame of 0x5A is received correctly.
- Reset mid-frame: HRESETn low after 3 bits while SSn stays low -> all outputs at reset values; after release, no activity until SSn toggles high then low; the following frame works.
